// File: rtl/cost_calculator.sv
// Squared-error cost between a one-hot digit label and ten 4-bit Q1.3 weights.
// One digit is accumulated per clock after a start pulse; the result is held until the next completion.
module cost_calculator (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            cost_en,
  input  logic [0:9]      expected_label,
  input  logic [0:9][3:0] digit_weights,
  output logic            calculation_complete,
  output logic [7:0]      cost_output
);

  localparam int unsigned NUM_DIGITS = 10;
  localparam logic [3:0]  LAST_IDX   = 4'(NUM_DIGITS);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [7:0]        acc_q, acc_d;
  logic [7:0]        cost_q, cost_d;
  logic [0:9]        label_q, label_d;
  logic [0:9][3:0]   weights_q, weights_d;

  logic              cur_label;
  logic [3:0]        cur_weight;
  logic [3:0]        target;
  logic [3:0]        diff;
  logic [7:0]        diff_w;
  logic [7:0]        sq;
  logic [3:0]        term;

  // Per-digit term from the latched copies; idx 10 is the settle cycle and selects nothing.
  always_comb begin
    cur_label  = 1'b0;
    cur_weight = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == 4'(i)) begin
        cur_label  = label_q[i];
        cur_weight = weights_q[i];
      end
    end
    target = {cur_label, 3'b000};
    diff   = (target >= cur_weight) ? (target - cur_weight) : (cur_weight - target);
    diff_w = {4'b0000, diff};
    sq     = diff_w * diff_w;
    term   = 4'(sq >> 3);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      cost_q    <= '0;
      label_q   <= '0;
      weights_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      cost_q    <= cost_d;
      label_q   <= label_d;
      weights_q <= weights_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    cost_d    = cost_q;
    label_d   = label_q;
    weights_d = weights_q;
    unique case (state_q)
      IDLE: begin
        if (cost_en) begin
          label_d   = expected_label;
          weights_d = digit_weights;
          acc_d     = '0;
          idx_d     = '0;
          state_d   = CALC;
        end
      end
      CALC: begin
        if (idx_q == LAST_IDX) begin
          cost_d  = acc_q;
          state_d = DONE;
        end else begin
          acc_d = acc_q + {4'b0000, term};
          idx_d = idx_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    calculation_complete = (state_q == DONE);
    cost_output          = cost_q;
  end

endmodule

// File: tb/tb_cost_calculator.sv
// Directed and randomized checks of cost_calculator against an arithmetic reference of the cost formula.
module tb_cost_calculator;

  logic            clk;
  logic            n_rst;
  logic            cost_en;
  logic [0:9]      expected_label;
  logic [0:9][3:0] digit_weights;
  logic            calculation_complete;
  logic [7:0]      cost_output;

  int n_checks;
  int n_fail;

  cost_calculator dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .cost_en              (cost_en),
    .expected_label       (expected_label),
    .digit_weights        (digit_weights),
    .calculation_complete (calculation_complete),
    .cost_output          (cost_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [0:9] onehot(input int d);
    logic [0:9] r;
    r = '0;
    r[d] = 1'b1;
    return r;
  endfunction

  function automatic logic [0:9][3:0] fill(input int w);
    logic [0:9][3:0] r;
    for (int i = 0; i < 10; i++) r[i] = 4'(w);
    return r;
  endfunction

  function automatic int ref_cost(input logic [0:9] lab, input logic [0:9][3:0] w);
    int sum, t, wi, d;
    sum = 0;
    for (int i = 0; i < 10; i++) begin
      t   = lab[i] ? 8 : 0;
      wi  = int'(w[i]);
      d   = (t > wi) ? t - wi : wi - t;
      sum = sum + ((d * d) / 8) % 16;
    end
    return sum;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  // Start at edge k, optionally scramble inputs after k+3 or hold cost_en through the run.
  task automatic do_run(input logic [0:9] lab, input logic [0:9][3:0] w,
                        input bit scramble, input bit hold_en, input string tag);
    int         exp_cost;
    int         pulses;
    logic [7:0] prev;
    exp_cost = ref_cost(lab, w);
    prev     = cost_output;
    @(negedge clk);
    expected_label = lab;
    digit_weights  = w;
    cost_en        = 1'b1;
    @(posedge clk); #1;
    if (!hold_en) cost_en = 1'b0;
    pulses = 0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      if (calculation_complete) pulses++;
      if (scramble && e == 3) begin
        expected_label = ~lab;
        for (int i = 0; i < 10; i++) digit_weights[i] = 4'($urandom_range(0, 15));
      end
    end
    check({tag, "_early_pulse"}, 32'(pulses), 32'd0);
    check({tag, "_held_prev"}, {24'd0, cost_output}, {24'd0, prev});
    @(posedge clk); #1;
    check({tag, "_complete"}, {31'd0, calculation_complete}, 32'd1);
    check({tag, "_cost"}, {24'd0, cost_output}, 32'(exp_cost));
    @(posedge clk); #1;
    cost_en = 1'b0;
    check({tag, "_complete_drop"}, {31'd0, calculation_complete}, 32'd0);
    pulses = 0;
    for (int e = 0; e < 14; e++) begin
      @(posedge clk); #1;
      if (calculation_complete) pulses++;
    end
    check({tag, "_no_extra_pulse"}, 32'(pulses), 32'd0);
    check({tag, "_cost_hold"}, {24'd0, cost_output}, 32'(exp_cost));
  endtask

  initial begin
    logic [0:9][3:0] w;
    logic [0:9]      lab;
    int              pulses;

    n_checks       = 0;
    n_fail         = 0;
    n_rst          = 1'b1;
    cost_en        = 1'b0;
    expected_label = '0;
    digit_weights  = '0;

    apply_reset();
    #1;
    check("reset_cost", {24'd0, cost_output}, 32'd0);
    check("reset_complete", {31'd0, calculation_complete}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("idle_cost", {24'd0, cost_output}, 32'd0);
    check("idle_complete", {31'd0, calculation_complete}, 32'd0);

    do_run(onehot(3), fill(0), 1'b0, 1'b0, "d3_w0");
    check("d3_w0_const", {24'd0, cost_output}, 32'd8);
    do_run(onehot(0), fill(8), 1'b0, 1'b0, "d0_w8");
    check("d0_w8_const", {24'd0, cost_output}, 32'd72);
    do_run(onehot(5), fill(4), 1'b0, 1'b0, "d5_w4");
    check("d5_w4_const", {24'd0, cost_output}, 32'd20);
    do_run(onehot(2), fill(3), 1'b0, 1'b0, "d2_w3");
    check("d2_w3_const", {24'd0, cost_output}, 32'd12);

    w = fill(0);
    w[0] = 4'd8;
    w[9] = 4'd15;
    do_run(onehot(0), w, 1'b0, 1'b0, "oor");
    check("oor_const", {24'd0, cost_output}, 32'd12);

    do_run(onehot(7), fill(6), 1'b1, 1'b0, "scramble");
    do_run(onehot(1), fill(2), 1'b0, 1'b1, "hold_en");

    // Abort mid-calculation with an asynchronous reset after edge k+5.
    @(negedge clk);
    expected_label = onehot(4);
    digit_weights  = fill(1);
    cost_en        = 1'b1;
    @(posedge clk); #1;
    cost_en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_rst = 1'b0;
    #1;
    check("abort_cost", {24'd0, cost_output}, 32'd0);
    check("abort_complete", {31'd0, calculation_complete}, 32'd0);
    @(negedge clk);
    n_rst  = 1'b1;
    pulses = 0;
    for (int e = 0; e < 15; e++) begin
      @(posedge clk); #1;
      if (calculation_complete) pulses++;
    end
    check("abort_no_pulse", 32'(pulses), 32'd0);
    check("abort_cost_after", {24'd0, cost_output}, 32'd0);

    for (int r = 0; r < 100; r++) begin
      apply_reset();
      lab = onehot(int'($urandom_range(0, 9)));
      for (int i = 0; i < 10; i++) w[i] = 4'($urandom_range(0, 8));
      do_run(lab, w, 1'b0, 1'b0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
